// File: rtl/huffman_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : huffman_packer                                                |
// | Brief    : Packs gray-level symbols (1..6) into an MSB-first byte stream |
// |            using a latched six-entry Huffman code table.                 |
// | Options  : HUFF_PACK_STATS_EN adds the saturating bit_count port.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module huffman_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        sym_valid,
  input  logic [7:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        done,
`ifdef HUFF_PACK_STATS_EN
  output logic [15:0] bit_count,
`endif
  output logic        err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [1:0]       r_state;
  logic [5:0][7:0]  r_hc;
  logic [5:0][3:0]  r_len;
  logic [15:0]      r_buf;
  logic [4:0]       r_fill;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_done;
  logic             r_err;

  logic [5:0][7:0]  w_hc_in;
  logic [5:0][7:0]  w_m_in;
  logic             w_accept;
  logic             w_sym_ok;
  logic             w_append;
  logic [2:0]       w_idx;
  logic [7:0]       w_code;
  logic [3:0]       w_len;
  logic             w_can_load;
  logic             w_pop;
  logic [4:0]       w_pop_amt;
  logic [4:0]       w_fill_pop;
  logic [15:0]      w_buf_pop;
  logic [15:0]      w_code_lj;
  logic [15:0]      w_buf_next;
  logic [4:0]       w_fill_next;

  assign w_hc_in = {HC6, HC5, HC4, HC3, HC2, HC1};
  assign w_m_in  = {M6, M5, M4, M3, M2, M1};

  assign sym_ready  = (r_state == c_RUN) && (r_fill <= 5'd8);
  assign w_accept   = sym_valid && sym_ready;
  assign w_can_load = !r_out_valid || out_ready;
  assign w_idx      = sym_data[2:0] - 3'd1;

  always_comb begin
    w_sym_ok = 1'b0;
    w_code   = 8'h00;
    w_len    = 4'd0;
    if (sym_data >= 8'd1 && sym_data <= 8'd6) begin
      w_code   = r_hc[w_idx];
      w_len    = r_len[w_idx];
      w_sym_ok = (r_len[w_idx] != 4'd0);
    end
  end

  assign w_append = w_accept && w_sym_ok;

  always_comb begin
    w_pop     = 1'b0;
    w_pop_amt = 5'd0;
    if (w_can_load) begin
      if (r_state == c_RUN && r_fill >= 5'd8) begin
        w_pop     = 1'b1;
        w_pop_amt = 5'd8;
      end else if (r_state == c_FLUSH && r_fill != 5'd0) begin
        w_pop     = 1'b1;
        w_pop_amt = (r_fill > 5'd8) ? 5'd8 : r_fill;
      end
    end
  end

  // New code is left-justified, then slid down past the bits surviving the pop.
  assign w_fill_pop  = r_fill - w_pop_amt;
  assign w_buf_pop   = w_pop ? {r_buf[7:0], 8'h00} : r_buf;
  assign w_code_lj   = {w_code, 8'h00} << (4'd8 - w_len);
  assign w_buf_next  = w_buf_pop | (w_append ? (w_code_lj >> w_fill_pop) : 16'h0000);
  assign w_fill_next = w_fill_pop + (w_append ? {1'b0, w_len} : 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_hc        <= '0;
      r_len       <= '0;
      r_buf       <= 16'h0000;
      r_fill      <= 5'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (code_valid) begin
            // Codes are stored pre-masked so stray high bits never leak into the stream.
            for (int i = 0; i < 6; i++) begin
              r_hc[i]  <= w_hc_in[i] & w_m_in[i];
              r_len[i] <= popcount8(w_m_in[i]);
            end
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          if (w_accept && sym_last) r_state <= c_FLUSH;
        end
        c_FLUSH: begin
          if (r_fill == 5'd0 && w_can_load) begin
            r_state <= c_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;

      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_buf[15:8];
        r_out_last  <= (r_state == c_FLUSH) && (r_fill <= 5'd8);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && !w_sym_ok) r_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;

`ifdef HUFF_PACK_STATS_EN
  logic [15:0] r_bit_count;
  logic [16:0] w_bc_sum;

  assign w_bc_sum = {1'b0, r_bit_count} + {13'd0, w_len};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_count <= 16'h0000;
    end else if (w_append) begin
      r_bit_count <= w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
    end
  end

  assign bit_count = r_bit_count;
`endif

endmodule
`default_nettype wire
